// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single RAM port between instruction fetch and
// the data path. One requester is granted at a time. Ties alternate using
// the most recently served requester. A RAM ERROR or a timeout is a sticky
// fault, cleared only by reset.
module memory_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        memerr
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, DATA, INST, ERR} state_t;
   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

   state_t        state, state_n;
   logic          last_inst, last_inst_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [31:0]   cap_addr, cap_addr_n;
   logic [31:0]   cap_store, cap_store_n;
   logic          cap_write, cap_write_n;

   logic dreq, access, ram_fault, req_held;

   assign dreq      = dREN | dWEN;
   assign access    = (ramstate == ACCESS);
   assign ram_fault = (ramstate == ERROR);
   assign req_held  = (state == DATA) ? dreq : iREN;

   // Read data is a passthrough; it is only meaningful while the matching wait is low.
   assign iload = ramload;
   assign dload = ramload;

   // State, arbitration history, timeout counter and captured request.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         last_inst <= 1'b1;
         cnt       <= '0;
         cap_addr  <= '0;
         cap_store <= '0;
         cap_write <= 1'b0;
      end else begin
         state     <= state_n;
         last_inst <= last_inst_n;
         cnt       <= cnt_n;
         cap_addr  <= cap_addr_n;
         cap_store <= cap_store_n;
         cap_write <= cap_write_n;
      end
   end

   // Next-state selection, request capture and RAM/cache side outputs.
   always_comb begin
      state_n     = state;
      last_inst_n = last_inst;
      cnt_n       = cnt;
      cap_addr_n  = cap_addr;
      cap_store_n = cap_store;
      cap_write_n = cap_write;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      iwait       = 1'b1;
      dwait       = 1'b1;
      memerr      = 1'b0;

      case (state)
         IDLE: begin
            cnt_n = '0;
            // Data wins a tie only when instruction was served last.
            if (dreq && (!iREN || last_inst)) begin
               state_n     = DATA;
               cap_addr_n  = daddr;
               cap_store_n = dstore;
               cap_write_n = dWEN;
            end else if (iREN) begin
               state_n     = INST;
               cap_addr_n  = iaddr;
               cap_store_n = '0;
               cap_write_n = 1'b0;
            end
         end
         DATA, INST: begin
            ramaddr  = cap_addr;
            ramstore = cap_store;
            ramREN   = (state == INST) || !cap_write;
            ramWEN   = (state == DATA) && cap_write;
            // Completion outranks fault and abort checks.
            if (access) begin
               if (state == DATA) dwait = 1'b0;
               else               iwait = 1'b0;
               state_n     = IDLE;
               last_inst_n = (state == INST);
               cnt_n       = '0;
            end else if (ram_fault || (cnt == TMO_LAST)) begin
               state_n = ERR;
            end else if (!req_held) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt != '1) begin
               cnt_n = cnt + CW'(1);
            end
         end
         ERR: begin
            memerr = 1'b1;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed stimulus with literal expectations, plus a
// transaction-level model compared against the DUT on every cycle.
module tb_memory_arbiter;

   localparam int unsigned TMO = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic        iwait, dwait, ramREN, ramWEN, memerr;

   memory_arbiter #(.TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .memerr(memerr)
   );

   always #5 CLK = ~CLK;

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: who owns the RAM, how long it has waited,
   // who gets the next tie, and whether a fault has killed the port.
   bit          m_valid = 1'b0;
   bit          m_dead;
   int          m_owner;        // 0 nobody, 1 data, 2 instruction
   bit          m_prefer_data;
   int          m_waited;
   logic [31:0] m_addr, m_store;
   bit          m_write;
   bit          held;
   logic        e_ren, e_wen, e_iw, e_dw, e_err;

   // Compare on the falling edge, then advance the model by one rising edge.
   always @(negedge CLK) begin
      if (m_valid) begin
         e_ren = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1; e_err = m_dead;
         if (m_owner == 1) begin
            e_ren = !m_write;
            e_wen = m_write;
            e_dw  = (ramstate != 2'd2);
         end else if (m_owner == 2) begin
            e_ren = 1'b1;
            e_iw  = (ramstate != 2'd2);
         end
         check("m_ramREN", ramREN, e_ren);
         check("m_ramWEN", ramWEN, e_wen);
         check("m_iwait", iwait, e_iw);
         check("m_dwait", dwait, e_dw);
         check("m_memerr", memerr, e_err);
         check("m_iload", iload, ramload);
         check("m_dload", dload, ramload);
         if (m_owner != 0) check("m_ramaddr", ramaddr, m_addr);
         if (m_owner == 1 && m_write) check("m_ramstore", ramstore, m_store);
      end

      if (RST) begin
         m_valid = 1'b1; m_dead = 1'b0; m_owner = 0;
         m_prefer_data = 1'b1; m_waited = 0;
      end else if (m_valid && !m_dead) begin
         if (m_owner == 0) begin
            m_waited = 0;
            if ((dREN || dWEN) && (!iREN || m_prefer_data)) begin
               m_owner = 1; m_addr = daddr; m_store = dstore; m_write = dWEN;
            end else if (iREN) begin
               m_owner = 2; m_addr = iaddr; m_write = 1'b0;
            end
         end else begin
            held = (m_owner == 1) ? (dREN || dWEN) : iREN;
            if (ramstate == 2'd2) begin
               m_prefer_data = (m_owner == 2);
               m_owner = 0;
            end else if (ramstate == 2'd3 || m_waited + 1 >= int'(TMO)) begin
               m_dead = 1'b1;
               m_owner = 0;
            end else if (!held) begin
               m_owner = 0;
            end else begin
               m_waited++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ramREN"}, ramREN, 1'b0);
      check({tag, "_ramWEN"}, ramWEN, 1'b0);
      check({tag, "_ramaddr"}, ramaddr, 32'h0);
      check({tag, "_ramstore"}, ramstore, 32'h0);
      check({tag, "_iwait"}, iwait, 1'b1);
      check({tag, "_dwait"}, dwait, 1'b1);
      check({tag, "_memerr"}, memerr, 1'b0);
   endtask

   bit grant_data [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
      tick(); tick();
      #1 check_reset_values("reset");

      // Data read alone: two BUSY cycles then ACCESS.
      RST = 1'b0; dREN = 1'b1; daddr = 32'h100; ramstate = 2'd1;
      tick(); #1;
      check("rd_c1_ramREN", ramREN, 1'b1);
      check("rd_c1_ramaddr", ramaddr, 32'h100);
      check("rd_c1_dwait", dwait, 1'b1);
      tick(); daddr = 32'h200; #1;
      check("rd_c2_ramaddr_held", ramaddr, 32'h100);
      check("rd_c2_dwait", dwait, 1'b1);
      tick(); ramstate = 2'd2; ramload = 32'hDEADBEEF; #1;
      check("rd_c3_dwait", dwait, 1'b0);
      check("rd_c3_dload", dload, 32'hDEADBEEF);
      check("rd_c3_iwait", iwait, 1'b1);
      tick(); dREN = 1'b0; daddr = '0; ramstate = 2'd0; #1;
      check("rd_c4_idle_ramREN", ramREN, 1'b0);
      check("rd_c4_dwait", dwait, 1'b1);

      // Contention after reset: grants alternate D,I,D,I.
      RST = 1'b1;
      tick();
      RST = 1'b0; iREN = 1'b1; dWEN = 1'b1; daddr = 32'h40; dstore = 32'hA5A5A5A5;
      iaddr = 32'h80; ramstate = 2'd2; ramload = 32'h11112222;
      for (int k = 0; k < 4; k++) begin
         tick(); #1;
         if (grant_data[k]) begin
            check("tie_data_ramWEN", ramWEN, 1'b1);
            check("tie_data_ramstore", ramstore, 32'hA5A5A5A5);
            check("tie_data_dwait", dwait, 1'b0);
            check("tie_data_iwait", iwait, 1'b1);
         end else begin
            check("tie_inst_ramREN", ramREN, 1'b1);
            check("tie_inst_ramaddr", ramaddr, 32'h80);
            check("tie_inst_iwait", iwait, 1'b0);
            check("tie_inst_dwait", dwait, 1'b1);
         end
         tick(); #1;
         check("tie_gap_ramREN", ramREN, 1'b0);
         check("tie_gap_ramWEN", ramWEN, 1'b0);
      end
      iREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0;

      // Abort: data drops its enable in the second granted cycle.
      tick();
      dREN = 1'b1; daddr = 32'h300; iREN = 1'b1; iaddr = 32'h400; ramstate = 2'd1;
      tick(); #1;
      check("ab_data_ramREN", ramREN, 1'b1);
      check("ab_data_ramaddr", ramaddr, 32'h300);
      tick(); dREN = 1'b0; #1;
      check("ab_drop_dwait", dwait, 1'b1);
      tick(); #1;
      check("ab_idle_ramREN", ramREN, 1'b0);
      check("ab_idle_iwait", iwait, 1'b1);
      tick(); #1;
      check("ab_inst_ramREN", ramREN, 1'b1);
      check("ab_inst_ramaddr", ramaddr, 32'h400);
      tick(); tick(); tick(); ramstate = 2'd2; ramload = 32'h0BADF00D; #1;
      check("ab_inst_late_iwait", iwait, 1'b0);
      check("ab_inst_late_memerr", memerr, 1'b0);
      check("ab_inst_late_iload", iload, 32'h0BADF00D);
      tick(); iREN = 1'b0; ramstate = 2'd0; #1;
      check("ab_after_iwait", iwait, 1'b1);

      // Timeout: instruction stuck BUSY.
      iREN = 1'b1; iaddr = 32'h500; ramstate = 2'd1;
      for (int k = 1; k <= 4; k++) begin
         tick(); #1;
         check("to_wait_memerr", memerr, 1'b0);
         check("to_wait_ramREN", ramREN, 1'b1);
      end
      tick(); #1;
      check("to_fault_memerr", memerr, 1'b1);
      check("to_fault_ramREN", ramREN, 1'b0);
      check("to_fault_iwait", iwait, 1'b1);
      check("to_fault_dwait", dwait, 1'b1);
      iREN = 1'b0; dREN = 1'b1; ramstate = 2'd2;
      tick(); #1;
      check("to_held_memerr", memerr, 1'b1);
      check("to_held_dwait", dwait, 1'b1);
      check("to_held_ramREN", ramREN, 1'b0);
      dREN = 1'b0; ramstate = 2'd0;

      // RAM ERROR during a data write.
      RST = 1'b1;
      tick(); #1;
      check("er_rst_memerr", memerr, 1'b0);
      RST = 1'b0; dWEN = 1'b1; daddr = 32'h600; dstore = 32'h12345678; ramstate = 2'd1;
      tick(); #1;
      check("er_wr_ramWEN", ramWEN, 1'b1);
      check("er_wr_ramaddr", ramaddr, 32'h600);
      check("er_wr_ramstore", ramstore, 32'h12345678);
      ramstate = 2'd3;
      tick(); #1;
      check("er_fault_memerr", memerr, 1'b1);
      check("er_fault_ramWEN", ramWEN, 1'b0);
      check("er_fault_dwait", dwait, 1'b1);
      ramstate = 2'd0; dWEN = 1'b0;
      tick(); #1;
      check("er_sticky_memerr", memerr, 1'b1);
      RST = 1'b1;
      tick(); #1;
      check_reset_values("er_clear");

      // Reset mid-grant, then data wins the next tie.
      RST = 1'b0; iREN = 1'b1; iaddr = 32'h700; ramstate = 2'd1;
      tick(); #1;
      check("mr_inst_ramREN", ramREN, 1'b1);
      check("mr_inst_ramaddr", ramaddr, 32'h700);
      RST = 1'b1;
      tick(); #1;
      check("mr_rst_ramREN", ramREN, 1'b0);
      check("mr_rst_iwait", iwait, 1'b1);
      check("mr_rst_memerr", memerr, 1'b0);
      RST = 1'b0; dREN = 1'b1; daddr = 32'h800; ramstate = 2'd2; ramload = 32'hCAFEF00D;
      tick(); #1;
      check("mr_tie_ramaddr", ramaddr, 32'h800);
      check("mr_tie_ramREN", ramREN, 1'b1);
      check("mr_tie_dwait", dwait, 1'b0);
      check("mr_tie_iwait", iwait, 1'b1);
      check("mr_tie_dload", dload, 32'hCAFEF00D);
      iREN = 1'b0; dREN = 1'b0; ramstate = 2'd0;
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
